uart_receiver: RTL and testbench

// - Serial RX front end of the UART; fills the RX queue in uart_datapath.
// - Synchronises the rxd pin, detects the start bit and samples the frame at 16x oversampling.
// - Supported frames: 5-8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// - Delivers each byte as a one-cycle write strobe plus per-frame error pulses for the IF register.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/parity_serial_calculator.sv | 24 ++
 rtl/uart_receiver.sv | 160 ++++++++++++++++
 tb/tb_uart_receiver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Receiver FSM states, config_b field layout and parity bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    DONE,
    WAIT_HIGH
  } uart_rx_state_t;

  localparam int PARITY_EN_BIT  = 0;
  localparam int PARITY_ODD_BIT = 1;
  localparam int DATA_BITS_BASE = 5;

  typedef struct packed {
    logic [1:0] data_bits_count;
    logic [1:0] parity_type;
    logic       double_stop_bits;
  } uart_config_b_t;

endpackage

// File: rtl/parity_serial_calculator.sv
// rtl/parity_serial_calculator.sv - running parity over a serial bit stream
// Accumulates XOR of din on each we; parity output is inverted for odd parity.
module parity_serial_calculator (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic din,
  input  logic odd,
  output logic parity
);

  logic acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= 1'b0;
    end else if (we) begin
      acc_q <= acc_q ^ din;
    end
  end

  assign parity = acc_q ^ odd;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampled UART receive front end
// Synchronises rxd, frames 5-8 data bits with optional parity and 1/2 stop bits.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic       rxd,
  input  logic [1:0] data_bits_count,
  input  logic [1:0] parity_type,
  input  logic       double_stop_bits,
  input  logic       rx_queue_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       stop_bit_error,
  output logic       overrun,
  output logic       busy
);

  localparam int             TW           = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]  MID_TICK     = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]  LAST_TICK    = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]     LAST_BIT_OFS = 3'(DATA_BITS_BASE - 1);

  uart_config_b_t       cfg;
  logic [SYNC_STAGES-1:0] sync_q;
  uart_rx_state_t       state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [7:0]           shreg_q;
  logic [7:0]           rx_data_q;
  logic [7:0]           rx_data_d;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 rxs;
  logic                 mid_tick;
  logic                 bit_tick;
  logic                 last_bit;
  logic                 calc_parity;
  logic                 done;

  assign cfg = '{data_bits_count: data_bits_count,
                 parity_type: parity_type,
                 double_stop_bits: double_stop_bits};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign mid_tick  = sample_en && (tick_cnt_q == MID_TICK);
  assign bit_tick  = sample_en && (tick_cnt_q == LAST_TICK);
  assign last_bit  = bit_cnt_q == ({1'b0, cfg.data_bits_count} + LAST_BIT_OFS);
  // Shorter words arrive in the top bits of the shift register; right-align them.
  assign rx_data_d = shreg_q >> (2'd3 - cfg.data_bits_count);

  parity_serial_calculator u_parity (
    .clk    (clk),
    .reset  (reset | (state_q == START)),
    .we     ((state_q == DATA) && bit_tick),
    .din    (rxs),
    .odd    (cfg.parity_type[PARITY_ODD_BIT]),
    .parity (calc_parity)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      if (sample_en) begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sample_en && !rxs) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
          end
        end
        START: begin
          if (mid_tick) begin
            state_q    <= rxs ? IDLE : DATA;
            tick_cnt_q <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shreg_q <= {rxs, shreg_q[7:1]};
            if (last_bit) begin
              bit_cnt_q <= '0;
              state_q   <= cfg.parity_type[PARITY_EN_BIT] ? PARITY : STOP1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            perr_q  <= rxs != calc_parity;
            state_q <= STOP1;
          end
        end
        STOP1: begin
          if (bit_tick) begin
            if (!rxs) ferr_q <= 1'b1;
            if (cfg.double_stop_bits) begin
              state_q <= STOP2;
            end else begin
              state_q   <= DONE;
              rx_data_q <= rx_data_d;
            end
          end
        end
        STOP2: begin
          if (bit_tick) begin
            if (!rxs) ferr_q <= 1'b1;
            state_q   <= DONE;
            rx_data_q <= rx_data_d;
          end
        end
        DONE: begin
          // A low line after a framing error is a break; wait for idle before rearming.
          state_q <= (ferr_q && !rxs) ? WAIT_HIGH : IDLE;
        end
        WAIT_HIGH: begin
          if (sample_en && rxs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done           = state_q == DONE;
  assign rx_data        = rx_data_q;
  assign rx_valid       = done && !rx_queue_full;
  assign overrun        = done && rx_queue_full;
  assign parity_error   = done && perr_q;
  assign stop_bit_error = done && ferr_q;
  assign busy           = state_q != IDLE;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
// Table of frames plus hand sequences; a scoreboard queue checks every output pulse.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en = 1'b0;
  logic       rxd;
  logic [1:0] data_bits_count;
  logic [1:0] parity_type;
  logic       double_stop_bits;
  logic       rx_queue_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       stop_bit_error;
  logic       overrun;
  logic       busy;

  uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_en        (sample_en),
    .rxd              (rxd),
    .data_bits_count  (data_bits_count),
    .parity_type      (parity_type),
    .double_stop_bits (double_stop_bits),
    .rx_queue_full    (rx_queue_full),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .parity_error     (parity_error),
    .stop_bit_error   (stop_bit_error),
    .overrun          (overrun),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         valid;
    bit         perr;
    bit         ferr;
    bit         ovr;
    int         lat;
    int         start_cyc;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] dbc;
    bit         pen;
    bit         odd;
    bit         bad;
    bit         two;
    bit         full;
    int         div;
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_perr;
    bit         exp_ovr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   tick_div = 1;
  int   div_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    sample_en = (div_cnt == 0);
    div_cnt   = (div_cnt + 1) % tick_div;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (rx_valid || overrun || parity_error || stop_bit_error)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: valid=%0b ovr=%0b perr=%0b ferr=%0b data=%0h",
                 rx_valid, overrun, parity_error, stop_bit_error, rx_data);
      end else begin
        e = sb.pop_front();
        chk("rx_valid", rx_valid, e.valid);
        chk("overrun", overrun, e.ovr);
        chk("parity_error", parity_error, e.perr);
        chk("stop_bit_error", stop_bit_error, e.ferr);
        if (e.valid) chk("rx_data", rx_data, e.data);
        if (e.lat >= 0) chk("latency", cyc - e.start_cyc, e.lat);
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * tick_div) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit pbit,
                            input bit two_stop, input bit stop2v, input bit final_idle,
                            input exp_t e);
    e.start_cyc = cyc;
    sb.push_back(e);
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nbits; i++) begin
      rxd = d[i];
      wait_ticks(16);
    end
    if (pen) begin
      rxd = pbit;
      wait_ticks(16);
    end
    rxd = 1'b1;
    wait_ticks(16);
    if (two_stop) begin
      rxd = stop2v;
      wait_ticks(16);
    end
    if (final_idle) begin
      rxd = 1'b1;
      wait_ticks(16);
    end
  endtask

  task automatic set_cfg(input logic [1:0] dbc, input bit pen, input bit odd, input bit two,
                         input int div);
    data_bits_count  = dbc;
    parity_type      = {odd, pen};
    double_stop_bits = two;
    tick_div         = div;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       v;
    exp_t       e;
    int         nbits;
    int         lat;
    logic [7:0] mask;
    bit         pbit;

    //          data   dbc   pen   odd   bad   two   full div exp   val   perr  ovr
    vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h15, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h15, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h15, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h15, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'h3F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 8'hC3, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h7E, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h7E, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{8'h42, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h42, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{8'hE9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 8'h09, 1'b1, 1'b0, 1'b0};

    reset            = 1'b1;
    rxd              = 1'b1;
    data_bits_count  = 2'd3;
    parity_type      = 2'd0;
    double_stop_bits = 1'b0;
    rx_queue_full    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_perr", parity_error, 1'b0);
    chk("reset_ferr", stop_bit_error, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      set_cfg(v.dbc, v.pen, v.odd, v.two, v.div);
      rx_queue_full = v.full;
      nbits = int'(v.dbc) + 5;
      mask  = 8'hFF >> (8 - nbits);
      pbit  = (^(v.data & mask)) ^ v.odd ^ v.bad;
      lat   = (v.div == 1) ? 11 + 16 * (nbits + int'(v.pen) + 1 + int'(v.two)) : -1;
      e     = '{v.exp_data, v.exp_valid, v.exp_perr, 1'b0, v.exp_ovr, lat, 0};
      send_frame(v.data, nbits, v.pen, pbit, v.two, 1'b1, 1'b1, e);
      rx_queue_full = 1'b0;
    end

    // Short low glitch: false start, back to idle with no pulses.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1);
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_busy_high", busy, 1'b1);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_busy_low", busy, 1'b0);

    // 8N2 with bad second stop bit, then the line stuck low.
    set_cfg(2'd3, 1'b0, 1'b0, 1'b1, 1);
    e = '{8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 11 + 16 * 10, 0};
    send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e);
    wait_ticks(40);
    chk("break_busy_held", busy, 1'b1);
    rxd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("break_busy_released", busy, 1'b0);
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 1);
    e = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 155, 0};
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, e);

    // Reset after three data bits aborts the frame.
    rxd = 1'b0;
    wait_ticks(16);
    rxd = 1'b1;
    wait_ticks(16);
    rxd = 1'b0;
    wait_ticks(16);
    rxd = 1'b0;
    wait_ticks(16);
    chk("midframe_busy", busy, 1'b1);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_rx_data", rx_data, 8'h00);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_rx_valid", rx_valid, 1'b0);
    chk("midreset_errors", {overrun, parity_error, stop_bit_error}, 3'b000);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    e = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 155, 0};
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, e);

    for (int k = 0; k < 400 && sb.size() > 0; k++) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
